parser_head_gather: RTL and testbench

//  Front end of the parser pipeline; sits directly upstream of the first parser layer.
//  - Accepts the packet beat stream (valid/ready/last).
//  - Packs the first HEAD_BEATS beats, MSB-first, into one head vector plus tag.
//  - Emits that head with an initial meta vector and first-layer exInfo (type/key offsets, head/meta shift).
//  - Forwards every beat unchanged on a payload stream that carries the packet id.

---
 rtl/parser_pkg.sv | 31 +++
 rtl/head_conf_regs.sv | 69 ++++++
 rtl/parser_head_gather.sv | 158 +++++++++++++++
 tb/tb_parser_head_gather.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parser_pkg.sv
// Shared constants and types for the parser front end: tag layout, conf map, gather FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package parser_pkg;

  localparam int HEAD_WIDTH        = 1024;
  localparam int TAG_WIDTH         = 9;
  localparam int PKTID_WIDTH       = TAG_WIDTH - 1;
  localparam int TAG_VALID_BIT     = TAG_WIDTH - 1;
  localparam int META_WIDTH        = 256;
  localparam int TS_WIDTH          = 32;

  localparam int TYPE_NUM          = 2;
  localparam int TYPE_OFFSET_WIDTH = 8;
  localparam int KEY_FILED_NUM     = 4;
  localparam int KEY_OFFSET_WIDTH  = 8;
  localparam int HEAD_SHIFT_WIDTH  = 8;
  localparam int META_SHIFT_WIDTH  = 8;

  localparam logic [7:0] CONF_TYPE_BASE = 8'h00;
  localparam logic [7:0] CONF_KEY_BASE  = 8'h10;
  localparam logic [7:0] CONF_HSHIFT    = 8'h20;
  localparam logic [7:0] CONF_MSHIFT    = 8'h21;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_PASS   = 2'd2
  } gather_state_e;

endpackage

// File: rtl/head_conf_regs.sv
// First-layer conf register file with a per-packet snapshot taken at SOP.
// Latency: writes land next cycle; outputs show live values in the SOP cycle, the snapshot after.
// Backpressure: none; conf writes are always accepted.
module head_conf_regs
  import parser_pkg::*;
(
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          wren_i,
  input  logic [31:0]                                   addr_i,
  input  logic [31:0]                                   wdata_i,
  input  logic                                          sop_i,
  output logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]         type_offset_o,
  output logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] key_offset_o,
  output logic [HEAD_SHIFT_WIDTH-1:0]                   head_shift_o,
  output logic [META_SHIFT_WIDTH-1:0]                   meta_shift_o
);

  localparam int KW = KEY_OFFSET_WIDTH + 1;

  logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] type_q, type_snap_q;
  logic [KEY_FILED_NUM-1:0][KW-1:0]           key_q, key_snap_q;
  logic [HEAD_SHIFT_WIDTH-1:0]                hshift_q, hshift_snap_q;
  logic [META_SHIFT_WIDTH-1:0]                mshift_q, mshift_snap_q;
  logic [7:0]                                 addr_lo;
  logic                                       unused_conf_bits;

  assign addr_lo          = addr_i[7:0];
  assign unused_conf_bits = ^{addr_i[31:8], wdata_i[31:KW]};

  // Decode conf writes into the live register file; unmapped addresses fall through.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      type_q   <= '0;
      key_q    <= '0;
      hshift_q <= '0;
      mshift_q <= '0;
    end else if (wren_i) begin
      for (int k = 0; k < TYPE_NUM; k++)
        if (addr_lo == CONF_TYPE_BASE + 8'(k)) type_q[k] <= wdata_i[TYPE_OFFSET_WIDTH-1:0];
      for (int k = 0; k < KEY_FILED_NUM; k++)
        if (addr_lo == CONF_KEY_BASE + 8'(k)) key_q[k] <= wdata_i[KW-1:0];
      if (addr_lo == CONF_HSHIFT) hshift_q <= wdata_i[HEAD_SHIFT_WIDTH-1:0];
      if (addr_lo == CONF_MSHIFT) mshift_q <= wdata_i[META_SHIFT_WIDTH-1:0];
    end
  end

  // Freeze the pre-write values at SOP so a packet in flight keeps its conf.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      type_snap_q   <= '0;
      key_snap_q    <= '0;
      hshift_snap_q <= '0;
      mshift_snap_q <= '0;
    end else if (sop_i) begin
      type_snap_q   <= type_q;
      key_snap_q    <= key_q;
      hshift_snap_q <= hshift_q;
      mshift_snap_q <= mshift_q;
    end
  end

  // A one-beat packet emits in its SOP cycle, before the snapshot register has loaded.
  assign type_offset_o = sop_i ? type_q   : type_snap_q;
  assign key_offset_o  = sop_i ? key_q    : key_snap_q;
  assign head_shift_o  = sop_i ? hshift_q : hshift_snap_q;
  assign meta_shift_o  = sop_i ? mshift_q : mshift_snap_q;

endmodule

// File: rtl/parser_head_gather.sv
// Gathers the first HEAD_BEATS beats of each packet into one head, emits it with first-layer exInfo, forwards every beat.
// Latency: head/meta/offsets registered 1 cycle after the completing beat; payload passthrough is combinational.
// Backpressure: input ready follows i_pass_ready only; the emit side never stalls. Option macro: TIMESTAMP_META_EN.
module parser_head_gather
  import parser_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic                                          i_data_valid,
  input  logic [DATA_WIDTH-1:0]                         i_data,
  input  logic                                          i_data_last,
  output logic                                          o_data_ready,
  output logic                                          o_pass_valid,
  output logic [DATA_WIDTH-1:0]                         o_pass_data,
  output logic                                          o_pass_last,
  output logic [PKTID_WIDTH-1:0]                        o_pass_pktid,
  input  logic                                          i_pass_ready,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]               o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0]               o_meta,
  output logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]         o_type_offset,
  output logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] o_key_offset,
  output logic [HEAD_SHIFT_WIDTH-1:0]                   o_headShift,
  output logic [META_SHIFT_WIDTH-1:0]                   o_metaShift,
  input  logic                                          i_conf_wren,
  input  logic [31:0]                                   i_conf_addr,
  input  logic [31:0]                                   i_conf_wdata
);

  localparam int HEAD_BEATS = HEAD_WIDTH / DATA_WIDTH;
  localparam int CNT_WIDTH  = $clog2(HEAD_BEATS + 1);

  gather_state_e                          state_q;
  logic [HEAD_BEATS-1:0][DATA_WIDTH-1:0]  asm_q, asm_d;
  logic [CNT_WIDTH-1:0]                   cnt_q, cnt_d;
  logic [PKTID_WIDTH-1:0]                 next_id_q, pkt_id_q, pass_id;
  logic [HEAD_WIDTH-1:0]                  head_q;
  logic                                   head_vld_q;
  logic [PKTID_WIDTH-1:0]                 head_id_q;
  logic [META_WIDTH-1:0]                  meta_q, meta_d;
  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]  type_off_q, conf_type;
  logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] key_off_q, conf_key;
  logic [HEAD_SHIFT_WIDTH-1:0]            hshift_q, conf_hshift;
  logic [META_SHIFT_WIDTH-1:0]            mshift_q, conf_mshift;
  logic                                   accept, sop, done;

  assign o_data_ready = i_pass_ready & ~i_rst;
  assign accept       = i_data_valid & o_data_ready;
  assign sop          = accept & (state_q == S_IDLE);
  // In S_IDLE the beat on the bus belongs to the packet about to start.
  assign pass_id      = (state_q == S_IDLE) ? next_id_q : pkt_id_q;

  assign o_pass_valid = i_data_valid;
  assign o_pass_data  = i_data;
  assign o_pass_last  = i_data_last;
  assign o_pass_pktid = pass_id;

  head_conf_regs u_conf (
    .clk_i         (i_clk),
    .rst_i         (i_rst),
    .wren_i        (i_conf_wren),
    .addr_i        (i_conf_addr),
    .wdata_i       (i_conf_wdata),
    .sop_i         (sop),
    .type_offset_o (conf_type),
    .key_offset_o  (conf_key),
    .head_shift_o  (conf_hshift),
    .meta_shift_o  (conf_mshift)
  );

`ifdef TIMESTAMP_META_EN
  logic [TS_WIDTH-1:0] ts_q, ts_snap_q;

  // Free-running cycle counter, sampled at SOP for the packet's meta.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ts_q      <= '0;
      ts_snap_q <= '0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
      if (sop) ts_snap_q <= ts_q;
    end
  end

  assign meta_d = META_WIDTH'(sop ? ts_q : ts_snap_q);
`else
  assign meta_d = '0;
`endif

  // Next assemble buffer: SOP clears the unfilled slots, later beats land in slot cnt (slot 0 at MSB).
  always_comb begin
    asm_d = asm_q;
    cnt_d = cnt_q;
    if (accept) begin
      if (state_q == S_IDLE) begin
        asm_d                 = '0;
        asm_d[HEAD_BEATS-1]   = i_data;
        cnt_d                 = CNT_WIDTH'(1);
      end else if (state_q == S_GATHER) begin
        for (int s = 0; s < HEAD_BEATS; s++)
          if (cnt_q == CNT_WIDTH'(s)) asm_d[HEAD_BEATS-1-s] = i_data;
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign done = accept & (state_q != S_PASS) & ((cnt_d == CNT_WIDTH'(HEAD_BEATS)) | i_data_last);

  // Gather FSM plus the output-side copy of the head; the separate output copy lets a new SOP assemble while the last head is presented.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      asm_q      <= '0;
      cnt_q      <= '0;
      next_id_q  <= '0;
      pkt_id_q   <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      head_id_q  <= '0;
      meta_q     <= '0;
      type_off_q <= '0;
      key_off_q  <= '0;
      hshift_q   <= '0;
      mshift_q   <= '0;
    end else begin
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      head_vld_q <= 1'b0;
      if (sop) pkt_id_q <= next_id_q;
      if (done) begin
        head_q     <= asm_d;
        head_vld_q <= 1'b1;
        head_id_q  <= pass_id;
        meta_q     <= meta_d;
        type_off_q <= conf_type;
        key_off_q  <= conf_key;
        hshift_q   <= conf_hshift;
        mshift_q   <= conf_mshift;
        next_id_q  <= next_id_q + PKTID_WIDTH'(1);
      end
      case (state_q)
        S_IDLE:   if (accept) state_q <= done ? (i_data_last ? S_IDLE : S_PASS) : S_GATHER;
        S_GATHER: if (done) state_q <= i_data_last ? S_IDLE : S_PASS;
        S_PASS:   if (accept && i_data_last) state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign o_head        = {head_q, head_vld_q, head_id_q};
  assign o_meta        = {meta_q, head_vld_q, head_id_q};
  assign o_type_offset = type_off_q;
  assign o_key_offset  = key_off_q;
  assign o_headShift   = hshift_q;
  assign o_metaShift   = mshift_q;

endmodule

// File: tb/tb_parser_head_gather.sv
// Directed bench for parser_head_gather with HEAD_BEATS = 2 (512-bit beats, 1024-bit head).
// Latency: emits expected one cycle after the completing beat.
// Backpressure: exercised through i_pass_ready.
module tb_parser_head_gather;
  import parser_pkg::*;

  localparam int DW = 512;
  localparam int KW = KEY_OFFSET_WIDTH + 1;

  logic                                  i_clk = 1'b0;
  logic                                  i_rst;
  logic                                  i_data_valid;
  logic [DW-1:0]                         i_data;
  logic                                  i_data_last;
  logic                                  o_data_ready;
  logic                                  o_pass_valid;
  logic [DW-1:0]                         o_pass_data;
  logic                                  o_pass_last;
  logic [PKTID_WIDTH-1:0]                o_pass_pktid;
  logic                                  i_pass_ready;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0]       o_head;
  logic [META_WIDTH+TAG_WIDTH-1:0]       o_meta;
  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0] o_type_offset;
  logic [KEY_FILED_NUM*KW-1:0]           o_key_offset;
  logic [HEAD_SHIFT_WIDTH-1:0]           o_headShift;
  logic [META_SHIFT_WIDTH-1:0]           o_metaShift;
  logic                                  i_conf_wren;
  logic [31:0]                           i_conf_addr;
  logic [31:0]                           i_conf_wdata;

  logic [DW-1:0]         head_hi, head_lo;
  logic [TAG_WIDTH-1:0]  head_tag;
  logic [META_WIDTH-1:0] meta_fld;

  int n_cmp = 0;
  int n_bad = 0;

  assign head_hi  = o_head[TAG_WIDTH+DW +: DW];
  assign head_lo  = o_head[TAG_WIDTH +: DW];
  assign head_tag = o_head[TAG_WIDTH-1:0];
  assign meta_fld = o_meta[TAG_WIDTH +: META_WIDTH];

  always #5 i_clk = ~i_clk;

  parser_head_gather #(.DATA_WIDTH(DW)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data_valid  (i_data_valid),
    .i_data        (i_data),
    .i_data_last   (i_data_last),
    .o_data_ready  (o_data_ready),
    .o_pass_valid  (o_pass_valid),
    .o_pass_data   (o_pass_data),
    .o_pass_last   (o_pass_last),
    .o_pass_pktid  (o_pass_pktid),
    .i_pass_ready  (i_pass_ready),
    .o_head        (o_head),
    .o_meta        (o_meta),
    .o_type_offset (o_type_offset),
    .o_key_offset  (o_key_offset),
    .o_headShift   (o_headShift),
    .o_metaShift   (o_metaShift),
    .i_conf_wren   (i_conf_wren),
    .i_conf_addr   (i_conf_addr),
    .i_conf_wdata  (i_conf_wdata)
  );

  function automatic logic [DW-1:0] pat(input logic [7:0] b);
    pat = {8{b, 56'h0123456789ABCD}};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_data_valid = 1'b0;
    i_data       = '0;
    i_data_last  = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last);
    i_data_valid = 1'b1;
    i_data       = d;
    i_data_last  = last;
  endtask

  task automatic conf_wr(input logic [31:0] a, input logic [31:0] d);
    i_conf_wren  = 1'b1;
    i_conf_addr  = a;
    i_conf_wdata = d;
  endtask

  task automatic conf_off();
    i_conf_wren  = 1'b0;
    i_conf_addr  = '0;
    i_conf_wdata = '0;
  endtask

  task automatic apply_reset();
    idle();
    conf_off();
    i_pass_ready = 1'b1;
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    conf_off();
    i_pass_ready = 1'b1;
    i_rst = 1'b1;
    #3;
    n_cmp++; if (o_head !== '0) begin n_bad++; $display("FAIL rst_head got %h exp 0", head_tag); end
    n_cmp++; if (o_meta !== '0) begin n_bad++; $display("FAIL rst_meta got %h exp 0", o_meta[TAG_WIDTH+31:0]); end
    n_cmp++; if (o_type_offset !== '0) begin n_bad++; $display("FAIL rst_type got %h exp 0", o_type_offset); end
    n_cmp++; if (o_key_offset !== '0) begin n_bad++; $display("FAIL rst_key got %h exp 0", o_key_offset); end
    n_cmp++; if (o_headShift !== '0) begin n_bad++; $display("FAIL rst_hshift got %h exp 0", o_headShift); end
    n_cmp++; if (o_metaShift !== '0) begin n_bad++; $display("FAIL rst_mshift got %h exp 0", o_metaShift); end
    n_cmp++; if (o_data_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b exp 0", o_data_ready); end
    tick();
    i_rst = 1'b0;
    #1;
    n_cmp++; if (o_data_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got %b exp 1", o_data_ready); end
    n_cmp++; if (o_pass_pktid !== '0) begin n_bad++; $display("FAIL post_rst_pktid got %h exp 0", o_pass_pktid); end
  endtask

  task automatic test_three_beat();
    apply_reset();
    beat(pat(8'hA1), 1'b0); tick();
    n_cmp++; if (head_tag[TAG_VALID_BIT] !== 1'b0) begin n_bad++; $display("FAIL t3_early_emit got %b exp 0", head_tag[TAG_VALID_BIT]); end
    beat(pat(8'hB2), 1'b0); tick();
    n_cmp++; if (head_hi !== pat(8'hA1)) begin n_bad++; $display("FAIL t3_head_hi got %h exp %h", head_hi, pat(8'hA1)); end
    n_cmp++; if (head_lo !== pat(8'hB2)) begin n_bad++; $display("FAIL t3_head_lo got %h exp %h", head_lo, pat(8'hB2)); end
    n_cmp++; if (head_tag !== {1'b1, PKTID_WIDTH'(0)}) begin n_bad++; $display("FAIL t3_tag got %h exp 100", head_tag); end
    beat(pat(8'hC3), 1'b1); #1;
    n_cmp++; if (o_pass_pktid !== PKTID_WIDTH'(0)) begin n_bad++; $display("FAIL t3_c_pktid got %h exp 0", o_pass_pktid); end
    n_cmp++; if (o_pass_data !== pat(8'hC3)) begin n_bad++; $display("FAIL t3_c_data got %h exp %h", o_pass_data, pat(8'hC3)); end
    n_cmp++; if ({o_pass_valid, o_pass_last} !== 2'b11) begin n_bad++; $display("FAIL t3_c_vl got %b exp 11", {o_pass_valid, o_pass_last}); end
    tick();
    idle();
    n_cmp++; if (head_tag !== {1'b0, PKTID_WIDTH'(0)}) begin n_bad++; $display("FAIL t3_tag_drop got %h exp 000", head_tag); end
    n_cmp++; if (head_hi !== pat(8'hA1)) begin n_bad++; $display("FAIL t3_head_held got %h exp %h", head_hi, pat(8'hA1)); end
  endtask

  task automatic test_one_beat();
`ifdef TIMESTAMP_META_EN
    logic [31:0] m0;
`endif
    apply_reset();
    beat(pat(8'h11), 1'b1); tick();
    n_cmp++; if (head_hi !== pat(8'h11)) begin n_bad++; $display("FAIL t1b_head_hi got %h exp %h", head_hi, pat(8'h11)); end
    n_cmp++; if (head_lo !== '0) begin n_bad++; $display("FAIL t1b_head_lo got %h exp 0", head_lo); end
    n_cmp++; if (head_tag !== {1'b1, PKTID_WIDTH'(0)}) begin n_bad++; $display("FAIL t1b_tag got %h exp 100", head_tag); end
`ifdef TIMESTAMP_META_EN
    m0 = o_meta[TAG_WIDTH +: 32];
`else
    n_cmp++; if (meta_fld !== '0) begin n_bad++; $display("FAIL t1b_meta got %h exp 0", meta_fld[31:0]); end
`endif
    beat(pat(8'h22), 1'b0); #1;
    n_cmp++; if (o_pass_pktid !== PKTID_WIDTH'(1)) begin n_bad++; $display("FAIL t1b_next_pktid got %h exp 1", o_pass_pktid); end
    tick();
    n_cmp++; if (head_tag[TAG_VALID_BIT] !== 1'b0) begin n_bad++; $display("FAIL t1b_sop_emit got %b exp 0", head_tag[TAG_VALID_BIT]); end
    beat(pat(8'h33), 1'b1); tick();
    idle();
    n_cmp++; if (head_hi !== pat(8'h22)) begin n_bad++; $display("FAIL t1b_p2_hi got %h exp %h", head_hi, pat(8'h22)); end
    n_cmp++; if (head_lo !== pat(8'h33)) begin n_bad++; $display("FAIL t1b_p2_lo got %h exp %h", head_lo, pat(8'h33)); end
    n_cmp++; if (head_tag !== {1'b1, PKTID_WIDTH'(1)}) begin n_bad++; $display("FAIL t1b_p2_tag got %h exp 101", head_tag); end
`ifdef TIMESTAMP_META_EN
    n_cmp++; if (o_meta[TAG_WIDTH +: 32] !== m0 + 32'd1) begin n_bad++; $display("FAIL t1b_ts got %h exp %h", o_meta[TAG_WIDTH +: 32], m0 + 32'd1); end
`endif
  endtask

  task automatic test_back_to_back();
    apply_reset();
    beat(pat(8'h40), 1'b0); tick();
    beat(pat(8'h41), 1'b1); tick();
    n_cmp++; if (head_hi !== pat(8'h40)) begin n_bad++; $display("FAIL b2b_p0_hi got %h exp %h", head_hi, pat(8'h40)); end
    n_cmp++; if (head_lo !== pat(8'h41)) begin n_bad++; $display("FAIL b2b_p0_lo got %h exp %h", head_lo, pat(8'h41)); end
    n_cmp++; if (head_tag !== {1'b1, PKTID_WIDTH'(0)}) begin n_bad++; $display("FAIL b2b_p0_tag got %h exp 100", head_tag); end
    beat(pat(8'h50), 1'b0); #1;
    n_cmp++; if (o_pass_pktid !== PKTID_WIDTH'(1)) begin n_bad++; $display("FAIL b2b_p1_pktid got %h exp 1", o_pass_pktid); end
    tick();
    n_cmp++; if (head_tag !== {1'b0, PKTID_WIDTH'(0)}) begin n_bad++; $display("FAIL b2b_gap_tag got %h exp 000", head_tag); end
    beat(pat(8'h51), 1'b1); tick();
    idle();
    n_cmp++; if (head_hi !== pat(8'h50)) begin n_bad++; $display("FAIL b2b_p1_hi got %h exp %h", head_hi, pat(8'h50)); end
    n_cmp++; if (head_lo !== pat(8'h51)) begin n_bad++; $display("FAIL b2b_p1_lo got %h exp %h", head_lo, pat(8'h51)); end
    n_cmp++; if (head_tag !== {1'b1, PKTID_WIDTH'(1)}) begin n_bad++; $display("FAIL b2b_p1_tag got %h exp 101", head_tag); end
    tick();
    n_cmp++; if (head_tag !== {1'b0, PKTID_WIDTH'(1)}) begin n_bad++; $display("FAIL b2b_end_tag got %h exp 001", head_tag); end
  endtask

  task automatic test_conf();
    apply_reset();
    beat(pat(8'h60), 1'b0); conf_wr(32'h00, 32'h6); tick();
    beat(pat(8'h61), 1'b1); conf_wr(32'h11, 32'h123); tick();
    idle(); conf_off();
    n_cmp++; if (o_type_offset !== 16'h0000) begin n_bad++; $display("FAIL conf_sop_type got %h exp 0000", o_type_offset); end
    n_cmp++; if (o_key_offset !== '0) begin n_bad++; $display("FAIL conf_sop_key got %h exp 0", o_key_offset); end
    n_cmp++; if (head_tag !== {1'b1, PKTID_WIDTH'(0)}) begin n_bad++; $display("FAIL conf_p0_tag got %h exp 100", head_tag); end
    conf_wr(32'h20, 32'h44); tick();
    conf_wr(32'h21, 32'h55); tick();
    conf_wr(32'h05, 32'h77); tick();
    conf_wr(32'h22, 32'h99); tick();
    conf_off();
    beat(pat(8'h62), 1'b1); tick();
    idle();
    n_cmp++; if (o_type_offset !== {8'h00, 8'h06}) begin n_bad++; $display("FAIL conf_type got %h exp 0006", o_type_offset); end
    n_cmp++; if (o_key_offset !== {9'h0, 9'h0, 9'h123, 9'h0}) begin n_bad++; $display("FAIL conf_key got %h exp %h", o_key_offset, {9'h0, 9'h0, 9'h123, 9'h0}); end
    n_cmp++; if (o_headShift !== 8'h44) begin n_bad++; $display("FAIL conf_hshift got %h exp 44", o_headShift); end
    n_cmp++; if (o_metaShift !== 8'h55) begin n_bad++; $display("FAIL conf_mshift got %h exp 55", o_metaShift); end
    n_cmp++; if (head_tag !== {1'b1, PKTID_WIDTH'(1)}) begin n_bad++; $display("FAIL conf_p1_tag got %h exp 101", head_tag); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    beat(pat(8'h70), 1'b0); tick();
    beat(pat(8'h71), 1'b1);
    i_pass_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (o_data_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d] got %b exp 0", i, o_data_ready); end
      n_cmp++; if (head_tag[TAG_VALID_BIT] !== 1'b0) begin n_bad++; $display("FAIL bp_emit[%0d] got %b exp 0", i, head_tag[TAG_VALID_BIT]); end
      tick();
    end
    i_pass_ready = 1'b1;
    tick();
    idle();
    n_cmp++; if (head_hi !== pat(8'h70)) begin n_bad++; $display("FAIL bp_head_hi got %h exp %h", head_hi, pat(8'h70)); end
    n_cmp++; if (head_lo !== pat(8'h71)) begin n_bad++; $display("FAIL bp_head_lo got %h exp %h", head_lo, pat(8'h71)); end
    n_cmp++; if (head_tag !== {1'b1, PKTID_WIDTH'(0)}) begin n_bad++; $display("FAIL bp_tag got %h exp 100", head_tag); end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    conf_wr(32'h20, 32'h44); tick();
    conf_off();
    beat(pat(8'h80), 1'b1); tick();
    n_cmp++; if (o_headShift !== 8'h44) begin n_bad++; $display("FAIL rmp_pre_hshift got %h exp 44", o_headShift); end
    beat(pat(8'h81), 1'b0); tick();
    idle();
    i_rst = 1'b1;
    #1;
    n_cmp++; if (o_head !== '0) begin n_bad++; $display("FAIL rmp_head got tag %h exp 0", head_tag); end
    n_cmp++; if (o_headShift !== '0) begin n_bad++; $display("FAIL rmp_hshift got %h exp 0", o_headShift); end
    n_cmp++; if (o_data_ready !== 1'b0) begin n_bad++; $display("FAIL rmp_ready got %b exp 0", o_data_ready); end
    tick();
    i_rst = 1'b0;
    beat(pat(8'h82), 1'b0); #1;
    n_cmp++; if (o_pass_pktid !== PKTID_WIDTH'(0)) begin n_bad++; $display("FAIL rmp_sop_pktid got %h exp 0", o_pass_pktid); end
    tick();
    n_cmp++; if (head_tag[TAG_VALID_BIT] !== 1'b0) begin n_bad++; $display("FAIL rmp_spurious_emit got %b exp 0", head_tag[TAG_VALID_BIT]); end
    beat(pat(8'h83), 1'b1); tick();
    idle();
    n_cmp++; if (head_hi !== pat(8'h82)) begin n_bad++; $display("FAIL rmp_head_hi got %h exp %h", head_hi, pat(8'h82)); end
    n_cmp++; if (head_lo !== pat(8'h83)) begin n_bad++; $display("FAIL rmp_head_lo got %h exp %h", head_lo, pat(8'h83)); end
    n_cmp++; if (head_tag !== {1'b1, PKTID_WIDTH'(0)}) begin n_bad++; $display("FAIL rmp_tag got %h exp 100", head_tag); end
    n_cmp++; if (o_headShift !== '0) begin n_bad++; $display("FAIL rmp_post_hshift got %h exp 0", o_headShift); end
  endtask

  initial begin
    i_rst = 1'b1;
    i_pass_ready = 1'b1;
    idle();
    conf_off();
    test_reset();
    test_three_beat();
    test_one_beat();
    test_back_to_back();
    test_conf();
    test_backpressure();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
